rfid_pie_tx: RTL and testbench

//  Reader-side PIE encoder (EPC C1G2 reader->tag link). Takes a command bit stream on a

---
 rtl/rfid_pie_tx.sv | 119 +++++++++++
 tb/tb_rfid_pie_tx.sv | 131 +++++++++++++
 2 files changed

// File: rtl/rfid_pie_tx.sv
// Reader-side PIE encoder: delimiter, preamble/frame-sync and PIE data symbols
// for the reader->tag link. The line idles at CW (high) between frames.
module rfid_pie_tx #(
  parameter int DELIM_CYC = 625,
  parameter int TARI_CYC  = 625,
  parameter int PW_CYC    = 313,
  parameter int TRCAL_CYC = 3750
) (
  input  logic clk_50m,
  input  logic rst_n,
  input  logic start,
  input  logic preamble_sel,
  input  logic bit_valid,
  input  logic bit_data,
  input  logic bit_last,
  output logic bit_ready,
  output logic dout,
  output logic busy,
  output logic done,
  output logic err
);

  typedef enum logic [2:0] {IDLE, DELIM, DATA0, RTCAL, TRCAL, SYM} state_e;

  localparam logic [15:0] DELIM_L = 16'(DELIM_CYC);
  localparam logic [15:0] TARI_L  = 16'(TARI_CYC);
  localparam logic [15:0] DATA1_L = 16'(2 * TARI_CYC);
  localparam logic [15:0] RTCAL_L = 16'(3 * TARI_CYC);
  localparam logic [15:0] TRCAL_L = 16'(TRCAL_CYC);
  localparam logic [15:0] PW_L    = 16'(PW_CYC);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        pre_q, pre_d;
  logic        last_q, last_d;
  logic        dout_q, dout_d;
  logic        field_end, fetch;

  // cnt_q holds the cycles left in the current field, including this one
  always_comb begin
    field_end = (cnt_q == 16'd1);
    fetch     = field_end && ((state_q == RTCAL && !pre_q) || state_q == TRCAL ||
                              (state_q == SYM && !last_q));
  end

  assign bit_ready = rst_n & fetch;
  assign err       = rst_n & fetch & ~bit_valid;
  assign done      = rst_n & field_end & (state_q == SYM) & last_q;
  assign busy      = (state_q != IDLE);
  assign dout      = dout_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q - 16'd1;
    pre_d   = pre_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d = DELIM;
          cnt_d   = DELIM_L;
          pre_d   = preamble_sel;
        end
      end
      DELIM: if (field_end) begin
        state_d = DATA0;
        cnt_d   = TARI_L;
      end
      DATA0: if (field_end) begin
        state_d = RTCAL;
        cnt_d   = RTCAL_L;
      end
      RTCAL: if (field_end && pre_q) begin
        state_d = TRCAL;
        cnt_d   = TRCAL_L;
      end
      TRCAL: ;
      SYM: if (field_end && last_q) begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    // Bit fetch on the last cycle of the field preceding each symbol
    if (fetch) begin
      if (bit_valid) begin
        state_d = SYM;
        cnt_d   = bit_data ? DATA1_L : TARI_L;
        last_d  = bit_last;
      end else begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    end
    // Every field after the delimiter ends with a PW-long low pulse
    dout_d = (state_d == IDLE) | ((state_d != DELIM) & (cnt_d > PW_L));
  end

  always_ff @(posedge clk_50m) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pre_q   <= 1'b0;
      last_q  <= 1'b0;
      dout_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      last_q  <= last_d;
      dout_q  <= dout_d;
    end
  end

endmodule

// File: tb/tb_rfid_pie_tx.sv
// Bench for rfid_pie_tx: expected line waveform built as per-cycle records from
// the frame's field lengths, compared against the DUT every cycle.
module tb_rfid_pie_tx;
  localparam int DELIM = 625;
  localparam int TARI  = 625;
  localparam int PW    = 313;
  localparam int TRCAL = 3750;
  localparam int T2_LEN = DELIM + TARI + 3 * TARI + TRCAL + TARI;

  logic clk_50m = 1'b0;
  logic rst_n = 1'b0, start = 1'b0, preamble_sel = 1'b0;
  logic bit_valid = 1'b0, bit_data = 1'b0, bit_last = 1'b0;
  logic bit_ready, dout, busy, done, err;

  int checks = 0;
  int errors = 0;
  // per-cycle record {dout, bit_ready, done, err, busy}
  logic [4:0] exp_q[$];

  rfid_pie_tx dut (
    .clk_50m(clk_50m), .rst_n(rst_n), .start(start), .preamble_sel(preamble_sel),
    .bit_valid(bit_valid), .bit_data(bit_data), .bit_last(bit_last),
    .bit_ready(bit_ready), .dout(dout), .busy(busy), .done(done), .err(err)
  );

  always #10 clk_50m = ~clk_50m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // field of len cycles: high for len-PW, low for PW; last cycle may fetch or finish
  task automatic add_field(input int len, input bit fetch, input bit fetch_ok, input bit fin);
    for (int i = 0; i < len; i++) begin
      bit lastc = (i == len - 1);
      exp_q.push_back({(i < len - PW), lastc & fetch, lastc & fin, lastc & fetch & ~fetch_ok, 1'b1});
    end
  endtask

  task automatic build_model(input bit pre, input int n, input logic [15:0] bits, input int nvalid);
    exp_q.delete();
    for (int i = 0; i < DELIM; i++) exp_q.push_back(5'b00001);
    add_field(TARI, 1'b0, 1'b0, 1'b0);
    add_field(3 * TARI, !pre, nvalid > 0, 1'b0);
    if (pre) add_field(TRCAL, 1'b1, nvalid > 0, 1'b0);
    if (nvalid == 0) return;
    for (int i = 0; i < n; i++) begin
      bit lst = (i == n - 1);
      add_field(bits[i] ? 2 * TARI : TARI, !lst, (i + 1) < nvalid, lst);
      if (!lst && (i + 1) >= nvalid) break;
    end
  endtask

  task automatic run_frame(input string tag, input bit pre, input int n, input logic [15:0] bits,
                           input int nvalid, input int poke0, input int poke1, input int rst_at);
    int idx = 0, xfer = 0, xfer_exp = 0, len;
    logic [4:0] rec;
    build_model(pre, n, bits, nvalid);
    if (rst_at >= 0) begin
      while (exp_q.size() > rst_at + 1) void'(exp_q.pop_back());
      rec = exp_q[rst_at];
      rec[3:1] = 3'b000;
      exp_q[rst_at] = rec;
    end
    foreach (exp_q[i]) if (exp_q[i][3] && !exp_q[i][1]) xfer_exp++;
    len = exp_q.size();
    @(posedge clk_50m); #1;
    start = 1'b1; preamble_sel = pre;
    bit_valid = (idx < nvalid); bit_data = bits[0]; bit_last = (n == 1);
    for (int c = 0; c <= len; c++) begin
      @(posedge clk_50m); #1;
      start = (c == poke0) || (c == poke1);
      rst_n = !(c == rst_at);
      preamble_sel = 1'($urandom);
      bit_valid = (idx < nvalid);
      bit_data  = (idx < n) ? bits[idx[3:0]] : 1'b0;
      bit_last  = (idx == n - 1);
      #1;
      if (c < len) chk({tag, "_cyc"}, 32'({dout, bit_ready, done, err, busy}), 32'(exp_q[c]));
      else         chk({tag, "_idle"}, 32'({dout, busy}), 32'd2);
      if (bit_ready && bit_valid) begin idx++; xfer++; end
    end
    start = 1'b0; rst_n = 1'b1; bit_valid = 1'b0;
    chk({tag, "_xfers"}, 32'(xfer), 32'(xfer_exp));
  endtask

  initial begin
    logic [15:0] rb;
    int rn, rv;
    bit rp;
    // T1: reset held with start asserted
    rst_n = 1'b0; start = 1'b1;
    repeat (3) @(posedge clk_50m);
    #1;
    chk("t1_reset", 32'({dout, busy, bit_ready, done, err}), 32'b10000);
    rst_n = 1'b1; start = 1'b0;
    @(posedge clk_50m); #1;
    chk("t1_idle", 32'({dout, busy, bit_ready}), 32'b100);

    // T2: preamble + single bit 0
    run_frame("t2", 1'b1, 1, 16'h0000, 1, -1, -1, -1);
    // T3: frame-sync + bits 1,0
    run_frame("t3", 1'b0, 2, 16'h0001, 2, -1, -1, -1);
    // T4: underrun at third fetch
    rb = 16'($urandom);
    run_frame("t4", 1'b1, 3, rb, 2, -1, -1, -1);
    // T5: starts at mid-RTcal and on the done cycle are ignored
    run_frame("t5", 1'b1, 1, 16'h0000, 1, DELIM + TARI + 900, T2_LEN - 1, -1);
    // T6: reset during TRcal low pulse, then a clean frame
    rb = 16'($urandom);
    run_frame("t6", 1'b1, 2, rb, 2, -1, -1, DELIM + TARI + 3 * TARI + TRCAL - 170);
    rb = 16'($urandom);
    run_frame("t6b", 1'b0, 2, rb, 2, -1, -1, -1);

    // randomized frames, occasionally with an underrun
    for (int f = 0; f < 3; f++) begin
      rb = 16'($urandom);
      rp = 1'($urandom);
      rn = int'($urandom_range(1, 5));
      rv = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, rn - 1)) : rn;
      run_frame("rnd", rp, rn, rb, rv, -1, -1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
